syn_sys_mem_resp: RTL and testbench
===================================

// Module: syn_sys_mem_resp
// PURPOSE
//  Responder (controller side) of the sys_mem interface that cortex drives as initiator.
//  Accepts single-beat writes/reads, applies back-pressure through mem_wait, returns read data at fixed latency.
//  Backed by on-chip RAM; models SDRAM init/refresh stalls. Used as in-FPGA stand-in controller and as a bench responder.
// PARAMETERS
//  DATA_W          32    mem_wdata/mem_rdata width
//  ADDR_W          27    mem_addr width
//  RAM_ADDR_W      10    backing RAM depth = 2**RAM_ADDR_W words
//  RD_LAT          3     accept-to-mem_rd_valid latency in cycles; legal range >= 2
//  REFRESH_PERIOD  780   RUN cycles between refresh bursts
//  REFRESH_CYCLES  8     cycles mem_wait held high per refresh
//  STALL_SEED      16'hACE1  LFSR seed, non-zero (used only with the macro below)
// PORTS
//  clk           in   1       clock
//  rst           in   1       asynchronous, active-high reset
//  mem_wren      in   1       write request
//  mem_rden      in   1       read request
//  mem_addr      in   ADDR_W  word address
//  mem_wdata     in   DATA_W  write data
//  mem_wait      out  1       registered; high = request not accepted this cycle
//  mem_rd_valid  out  1       read data valid, one pulse per accepted read
//  mem_rdata     out  DATA_W  read data
//  init_done     out  1       high once RAM clear is complete
//  err_sticky    out  1       wren and rden high together at an accepted request
//  oob_sticky    out  1       accepted request had mem_addr[ADDR_W-1:RAM_ADDR_W] != 0
// BEHAVIOUR
//  Reset: mem_wait=1, mem_rd_valid=0, mem_rdata=0, init_done=0, err_sticky=0, oob_sticky=0, FSM=INIT, pipeline flushed.
//  Accept: request accepted in any cycle with (mem_wren|mem_rden) & ~mem_wait; otherwise the initiator holds it.
//  FSM: INIT -> RUN once all 2**RAM_ADDR_W words are written 0 (one word/cycle, addr counter 0..max);
//   RUN -> REFRESH when refresh counter = REFRESH_PERIOD-1; REFRESH -> RUN after REFRESH_CYCLES cycles; counter reloads 0.
//  mem_wait is registered from the next state: high in every INIT and REFRESH cycle, low in RUN (stall macro aside).
//   Last RUN cycle before REFRESH still has mem_wait low; requests there are accepted.
//  Write: RAM[mem_addr[RAM_ADDR_W-1:0]] <= mem_wdata in the accept cycle.
//  Read: mem_rd_valid/mem_rdata appear exactly RD_LAT cycles after accept; back-to-back reads yield back-to-back valids.
//   RAM read is registered (1 cycle), then an RD_LAT-1 stage valid/data shift pipeline; mem_rdata holds last value when not valid.
//  Read immediately after write to the same address returns the new data (write in cycle N, read in N+1).
//  Reads in flight complete normally across REFRESH entry; the pipeline never stalls.
//  wren & rden together: write performed, read dropped (no rd_valid), err_sticky set.
//  Out-of-range address: write dropped, read returns 0 with normal valid timing, oob_sticky set.
//  Sticky flags clear only on rst. Reset mid-operation discards in-flight reads and restarts INIT.
// CONFIGURATION
//  SYN_SYS_MEM_RESP_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded STALL_SEED, steps every cycle;
//   in RUN, mem_wait also high when lfsr[1:0]==2'b00 (~25% random stall). Refresh and INIT behaviour unchanged.
//  Not defined: no LFSR logic; mem_wait depends only on FSM state.
// STRUCTURE
//  syn_sys_mem_resp_pkg: state enum {INIT,RUN,REFRESH}, LFSR width/tap constant, RD_LAT minimum check constant.
//  Sub-module syn_sys_mem_resp_ram: single-port RAM, registered read, one op/cycle (shared by init clear and requests).
//  Top: FSM, init address counter, refresh counter, read pipeline, sticky flags, optional LFSR.
// TESTING
//  1 Release rst: mem_wait=1 for exactly 2**RAM_ADDR_W cycles (1024), then init_done=1, mem_wait=0; read addr 5 -> 0.
//  2 Write 0xDEADBEEF @0x10, read @0x10 next cycle -> mem_rd_valid exactly 3 cycles after accept, rdata 0xDEADBEEF.
//  3 Eight back-to-back reads @0..7 (preloaded 0..7) -> eight consecutive valid pulses, data 0..7 in order.
//  4 Hold rden continuously: mem_wait high 8 cycles every 788, no request accepted then, in-flight read returns during refresh.
//  5 wren+rden @0x20 data 0x55 -> RAM[0x20]=0x55, no rd_valid, err_sticky=1; read @addr 1<<RAM_ADDR_W -> rdata 0, oob_sticky=1.
//  6 With SYN_SYS_MEM_RESP_STALL_EN, 10000 random requests vs scoreboard -> no data mismatch, stall rate 20-30%.

Source files
------------

// File: rtl/syn_sys_mem_resp_pkg.sv
// rtl/syn_sys_mem_resp_pkg.sv - shared constants and helpers for the sys_mem responder
//
// Purpose: FSM state encodings, stall LFSR width/taps and the minimum legal
//          read latency used by syn_sys_mem_resp and its RAM.
// Ports:   none (package).

package syn_sys_mem_resp_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_INIT    = 2'd0;
   localparam state_t ST_RUN     = 2'd1;
   localparam state_t ST_REFRESH = 2'd2;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10
   localparam int              LFSR_W    = 16;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   // One cycle for the registered RAM read plus at least one output stage
   localparam int RD_LAT_MIN = 2;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/syn_sys_mem_resp_ram.sv
// rtl/syn_sys_mem_resp_ram.sv - single-port backing RAM with registered read
//
// Purpose: one operation per cycle; shared by the init clear and by requests.
//          Read returns the pre-write contents on a same-cycle write.
// Ports:   clk              clock
//          en               operation enable
//          we               write enable (qualified by en)
//          addr [ADDR_W]    word address
//          wdata[DATA_W]    write data
//          rdata[DATA_W]    registered read data, valid the cycle after en

module syn_sys_mem_resp_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/syn_sys_mem_resp.sv
// rtl/syn_sys_mem_resp.sv - sys_mem responder backed by on-chip RAM
//
// Purpose: accepts single-beat reads/writes from the sys_mem initiator,
//          back-pressures through mem_wait during RAM clear and modelled
//          SDRAM refresh, returns read data exactly RD_LAT cycles after accept.
// Config:  define SYN_SYS_MEM_RESP_STALL_EN to add ~25% LFSR-driven random
//          stalls in RUN; undefined, mem_wait depends only on the FSM state.
// Ports:   clk, rst (async, active-high)
//          mem_wren, mem_rden, mem_addr[ADDR_W], mem_wdata[DATA_W]  request
//          mem_wait        registered; high = request not accepted
//          mem_rd_valid    one pulse per accepted read
//          mem_rdata       read data, holds last value when not valid
//          init_done       RAM clear complete
//          err_sticky      wren and rden seen together on an accepted request
//          oob_sticky      accepted request addressed beyond the RAM

module syn_sys_mem_resp
   import syn_sys_mem_resp_pkg::*;
#(
   parameter int          DATA_W         = 32,
   parameter int          ADDR_W         = 27,
   parameter int          RAM_ADDR_W     = 10,
   parameter int          RD_LAT         = 3,
   parameter int          REFRESH_PERIOD = 780,
   parameter int          REFRESH_CYCLES = 8,
   parameter logic [15:0] STALL_SEED     = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_wren,
   input  logic              mem_rden,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wait,
   output logic              mem_rd_valid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              init_done,
   output logic              err_sticky,
   output logic              oob_sticky
);

   generate
      if (RD_LAT < RD_LAT_MIN) begin : g_bad_rd_lat
         $error("syn_sys_mem_resp: RD_LAT must be >= 2");
      end
      if (STALL_SEED == 16'h0000) begin : g_bad_seed
         $error("syn_sys_mem_resp: STALL_SEED must be non-zero");
      end
   endgenerate

   localparam int CNT_MAX = (REFRESH_PERIOD > REFRESH_CYCLES) ? REFRESH_PERIOD : REFRESH_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PIPE_N  = RD_LAT - 1;

   state_t                state;
   state_t                next_state;
   logic [RAM_ADDR_W-1:0] init_addr;
   logic [CNT_W-1:0]      cnt;
   logic                  stall;

   logic                  accept;
   logic                  oob;

   logic                  ram_en;
   logic                  ram_we;
   logic [RAM_ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0]     ram_wdata;
   logic [DATA_W-1:0]     ram_rdata;

   logic                  rd_v0;
   logic                  rd_oob0;
   logic [DATA_W-1:0]     rd_din;
   logic [PIPE_N-1:0]     pv;
   logic [DATA_W-1:0]     pd [PIPE_N];

   // mem_wait is low only in RUN, so no request is ever accepted during clear
   assign accept = (mem_wren | mem_rden) & ~mem_wait;
   assign oob    = |mem_addr[ADDR_W-1:RAM_ADDR_W];

   always_comb begin
      next_state = state;
      case (state)
         ST_INIT:    if (&init_addr)                           next_state = ST_RUN;
         ST_RUN:     if (cnt == CNT_W'(REFRESH_PERIOD - 1))    next_state = ST_REFRESH;
         ST_REFRESH: if (cnt == CNT_W'(REFRESH_CYCLES - 1))    next_state = ST_RUN;
         default:                                              next_state = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_INIT;
         init_addr <= '0;
         cnt       <= '0;
         mem_wait  <= 1'b1;
         init_done <= 1'b0;
      end else begin
         state <= next_state;
         if (state == ST_INIT) begin
            init_addr <= init_addr + 1'b1;
         end
         // one counter serves both RUN period and REFRESH length
         if (state == ST_INIT || next_state != state) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         // registered from the next state so the last RUN cycle stays open
         mem_wait  <= (next_state != ST_RUN) | stall;
         init_done <= init_done | (next_state == ST_RUN);
      end
   end

`ifdef SYN_SYS_MEM_RESP_STALL_EN
   logic [LFSR_W-1:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= LFSR_W'(STALL_SEED);
      end else begin
         lfsr <= lfsr_next(lfsr);
      end
   end

   assign stall = (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // RAM port: clear writes own it during INIT, requests afterwards
   always_comb begin
      if (state == ST_INIT) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = init_addr;
         ram_wdata = '0;
      end else begin
         ram_en    = accept;
         ram_we    = accept & mem_wren & ~oob;
         ram_addr  = mem_addr[RAM_ADDR_W-1:0];
         ram_wdata = mem_wdata;
      end
   end

   syn_sys_mem_resp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (RAM_ADDR_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Out-of-range reads still travel the pipeline but deliver zero
   assign rd_din = rd_oob0 ? '0 : ram_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_v0   <= 1'b0;
         rd_oob0 <= 1'b0;
         pv      <= '0;
         for (int i = 0; i < PIPE_N; i++) begin
            pd[i] <= '0;
         end
      end else begin
         // a combined wren+rden request writes but never returns data
         rd_v0   <= accept & mem_rden & ~mem_wren;
         rd_oob0 <= oob;
         pv[0]   <= rd_v0;
         if (rd_v0) begin
            pd[0] <= rd_din;
         end
         for (int i = 1; i < PIPE_N; i++) begin
            pv[i] <= pv[i-1];
            if (pv[i-1]) begin
               pd[i] <= pd[i-1];
            end
         end
      end
   end

   assign mem_rd_valid = pv[PIPE_N-1];
   assign mem_rdata    = pd[PIPE_N-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sticky <= 1'b0;
         oob_sticky <= 1'b0;
      end else begin
         if (accept & mem_wren & mem_rden) begin
            err_sticky <= 1'b1;
         end
         if (accept & oob) begin
            oob_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_syn_sys_mem_resp.sv
// tb/tb_syn_sys_mem_resp.sv - directed self-checking bench for syn_sys_mem_resp

module tb_syn_sys_mem_resp;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 27;
   localparam int RAM_ADDR_W = 10;
   localparam int NV         = 13;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              mem_wren = 1'b0;
   logic              mem_rden = 1'b0;
   logic [ADDR_W-1:0] mem_addr = '0;
   logic [DATA_W-1:0] mem_wdata = '0;
   logic              mem_wait;
   logic              mem_rd_valid;
   logic [DATA_W-1:0] mem_rdata;
   logic              init_done;
   logic              err_sticky;
   logic              oob_sticky;

   syn_sys_mem_resp dut (
      .clk          (clk),
      .rst          (rst),
      .mem_wren     (mem_wren),
      .mem_rden     (mem_rden),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wait     (mem_wait),
      .mem_rd_valid (mem_rd_valid),
      .mem_rdata    (mem_rdata),
      .init_done    (init_done),
      .err_sticky   (err_sticky),
      .oob_sticky   (oob_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              wr;
      logic              rd;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              exp_v;
      logic [DATA_W-1:0] exp_d;
      logic              exp_err;
      logic              exp_oob;
   } vec_t;

   vec_t tbl [NV];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Presents a request, waits (bounded) for mem_wait low, returns one cycle after accept
   task automatic issue(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
      int n;
      mem_wren  = wr;
      mem_rden  = rd;
      mem_addr  = a;
      mem_wdata = d;
      n = 0;
      while (mem_wait && n < 100) begin
         cyc();
         n++;
      end
      chk("issue_accept_bound", 32'(mem_wait), 32'd0);
      cyc();
      mem_wren = 1'b0;
      mem_rden = 1'b0;
   endtask

   // Counts cycles from reset release until mem_wait drops
   task automatic init_count(output int n, output int stray_valid);
      n = 0;
      stray_valid = 0;
      while (mem_wait && n < 2000) begin
         if (mem_rd_valid) stray_valid++;
         cyc();
         n++;
      end
   endtask

   initial begin
      int n, stray, got, sent, first, last, t;
      int errs, bad_data, vw, nrise, nfall, wait_cnt, rise_t [4], hi_len [4], start_t;
      logic acc, prev_w;
      logic [2:0] hist;

      // wr rd addr wdata | exp_valid exp_data exp_err exp_oob
      tbl[0]  = '{1'b0, 1'b1, 27'd5,               32'h0,        1'b1, 32'h0,        1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 27'h10,              32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 27'h10,              32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 27'h3FF,             32'h12345678, 1'b0, 32'h0,        1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 27'h3FF,             32'h0,        1'b1, 32'h12345678, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 27'h0,               32'h0000CAFE, 1'b0, 32'h0,        1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 27'h0,               32'h0,        1'b1, 32'h0000CAFE, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 27'h20,              32'h55,       1'b0, 32'h0,        1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 27'h20,              32'h0,        1'b1, 32'h55,       1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 27'h400,             32'h0,        1'b1, 32'h0,        1'b1, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 27'h430,             32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, 1'b1};
      tbl[11] = '{1'b0, 1'b1, 27'h30,              32'h0,        1'b1, 32'h0,        1'b1, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 27'h10,              32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b1};

      // Reset values
      repeat (3) cyc();
      chk("rst_mem_wait",   32'(mem_wait),     32'd1);
      chk("rst_rd_valid",   32'(mem_rd_valid), 32'd0);
      chk("rst_rdata",      mem_rdata,         32'd0);
      chk("rst_init_done",  32'(init_done),    32'd0);
      chk("rst_err_sticky", 32'(err_sticky),   32'd0);
      chk("rst_oob_sticky", 32'(oob_sticky),   32'd0);

      // RAM clear takes one cycle per word
      rst = 1'b0;
      init_count(n, stray);
      chk("init_wait_cycles", 32'(n), 32'd1024);
      chk("init_done_set",    32'(init_done), 32'd1);
      chk("init_no_valid",    32'(stray), 32'd0);

      // Table-driven single requests
      for (int i = 0; i < NV; i++) begin
         issue(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata);
         chk($sformatf("vec%0d_valid_a1", i), 32'(mem_rd_valid), 32'd0);
         if (tbl[i].rd) begin
            cyc();
            chk($sformatf("vec%0d_valid_a2", i), 32'(mem_rd_valid), 32'd0);
            cyc();
            chk($sformatf("vec%0d_valid_a3", i), 32'(mem_rd_valid), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v) chk($sformatf("vec%0d_rdata", i), mem_rdata, tbl[i].exp_d);
         end
         chk($sformatf("vec%0d_err", i), 32'(err_sticky), 32'(tbl[i].exp_err));
         chk($sformatf("vec%0d_oob", i), 32'(oob_sticky), 32'(tbl[i].exp_oob));
      end

      // Back-to-back reads of preloaded words 0..7
      for (int i = 0; i < 8; i++) issue(1'b1, 1'b0, ADDR_W'(i), DATA_W'(i));
      got = 0; sent = 0; first = -1; last = -1; t = 0;
      mem_rden = 1'b1;
      mem_addr = '0;
      while (got < 8 && t < 100) begin
         if (mem_rd_valid) begin
            chk($sformatf("b2b_data%0d", got), mem_rdata, DATA_W'(got));
            if (first < 0) first = t;
            last = t;
            got++;
         end
         acc = mem_rden & ~mem_wait;
         cyc();
         t++;
         if (acc) begin
            sent++;
            if (sent == 8) mem_rden = 1'b0;
            else mem_addr = ADDR_W'(sent);
         end
      end
      chk("b2b_count", 32'(got), 32'd8);
`ifndef SYN_SYS_MEM_RESP_STALL_EN
      chk("b2b_consecutive", 32'(last - first), 32'd7);
`endif

      // Continuous reads across refresh bursts, valid timing modelled by accept history
      issue(1'b1, 1'b0, 27'h10, 32'hDEADBEEF);
      hist = '0; errs = 0; bad_data = 0; vw = 0; nrise = 0; nfall = 0; wait_cnt = 0;
      prev_w = mem_wait; start_t = 0;
      for (int i = 0; i < 4; i++) begin rise_t[i] = 0; hi_len[i] = 0; end
      mem_rden = 1'b1;
      mem_addr = 27'h10;
      for (int c = 0; c < 2000; c++) begin
         if (mem_rd_valid !== hist[2]) errs++;
         if (mem_rd_valid && mem_rdata !== 32'hDEADBEEF) bad_data++;
         if (mem_rd_valid && mem_wait) vw++;
         if (mem_wait) wait_cnt++;
         if (mem_wait && !prev_w) begin
            if (nrise < 4) rise_t[nrise] = c;
            nrise++;
            start_t = c;
         end
         if (!mem_wait && prev_w) begin
            if (nfall < 4) hi_len[nfall] = c - start_t;
            nfall++;
         end
         prev_w = mem_wait;
         hist = {hist[1:0], mem_rden & ~mem_wait};
         cyc();
      end
      mem_rden = 1'b0;
      repeat (4) cyc();
      chk("refresh_valid_timing", 32'(errs), 32'd0);
      chk("refresh_rdata",        32'(bad_data), 32'd0);
      chk("inflight_in_refresh",  32'(vw > 0), 32'd1);
`ifdef SYN_SYS_MEM_RESP_STALL_EN
      chk("stall_rate_20_30", 32'(wait_cnt >= 400 && wait_cnt <= 600), 32'd1);
`else
      chk("refresh_bursts_seen", 32'(nrise >= 2 && nfall >= 2), 32'd1);
      chk("refresh_len0",        32'(hi_len[0]), 32'd8);
      chk("refresh_len1",        32'(hi_len[1]), 32'd8);
      chk("refresh_period",      32'(rise_t[1] - rise_t[0]), 32'd788);
      chk("refresh_wait_total",  32'(wait_cnt >= 16 && wait_cnt <= 24), 32'd1);
`endif

      // Reset with a read in flight
      issue(1'b0, 1'b1, 27'h10, 32'h0);
      rst = 1'b1;
      #1;
      chk("midrst_rd_valid", 32'(mem_rd_valid), 32'd0);
      chk("midrst_mem_wait", 32'(mem_wait),     32'd1);
      chk("midrst_err",      32'(err_sticky),   32'd0);
      chk("midrst_oob",      32'(oob_sticky),   32'd0);
      chk("midrst_init",     32'(init_done),    32'd0);
      cyc();
      cyc();
      rst = 1'b0;
      init_count(n, stray);
      chk("reinit_wait_cycles", 32'(n), 32'd1024);
      chk("reinit_no_valid",    32'(stray), 32'd0);
      issue(1'b0, 1'b1, 27'h10, 32'h0);
      cyc();
      cyc();
      chk("reinit_valid",  32'(mem_rd_valid), 32'd1);
      chk("reinit_rdata",  mem_rdata, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
